dff_mem_master: RTL and testbench

Initiator-side controller for the 16x8 flip-flop RAM.
- Accepts single or burst read/write commands over a valid/ready command port.
- Streams write bytes in and read bytes out over valid/ready data ports.
- Drives the RAM's addr/data_in/lr_n/ce_n pins and captures its data_out.
- Sits between the CPU/loader logic and the RAM; it is the only agent allowed to drive the RAM control pins.

---
 rtl/dff_mem_pkg.sv | 15 +
 rtl/dff_mem_master.sv | 97 +++++++++
 tb/tb_dff_mem_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dff_mem_pkg.sv
// Shared sizes and state type for the flip-flop RAM initiator.
package dff_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned RAM_BYTES  = 2 ** ADDR_W_DEF;

   typedef enum logic [1:0] {
      StIdle,
      StWr,
      StRd,
      StRdOut
   } mem_master_state_t;

endpackage

// File: rtl/dff_mem_master.sv
// Burst read/write initiator for the 16x8 flip-flop RAM. Writes stream at one
// byte per cycle; reads take one RAM-enable cycle plus one output cycle per byte.
module dff_mem_master
   import dff_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_lr_n,
   output logic              mem_ce_n,
   output logic              busy,
   output logic              done
);

   mem_master_state_t state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] rem_q;

   // Handshakes are gated by rst_n so a reset cycle can never commit a RAM write.
   assign cmd_ready = rst_n && (state_q == StIdle);
   assign wr_ready  = rst_n && (state_q == StWr);
   assign busy      = (state_q != StIdle);
   assign mem_lr_n  = !(wr_ready && wr_valid);
   assign mem_ce_n  = !(rst_n && (state_q == StRd));
   assign mem_addr  = addr_q;
   assign mem_wdata = wr_ready ? wr_data : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         rem_q    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  rem_q   <= cmd_len;
                  state_q <= cmd_write ? StWr : StRd;
               end
            end
            StWr: begin
               if (wr_valid) begin
                  if (rem_q == '0) begin
                     state_q <= StIdle;
                     done    <= 1'b1;
                  end else begin
                     addr_q <= addr_q + ADDR_W'(1);
                     rem_q  <= rem_q - ADDR_W'(1);
                  end
               end
            end
            // mem_rdata is only sampled here, so a floating bus never reaches rd_data.
            StRd: begin
               rd_data  <= mem_rdata;
               rd_valid <= 1'b1;
               state_q  <= StRdOut;
            end
            StRdOut: begin
               if (rd_ready) begin
                  rd_valid <= 1'b0;
                  if (rem_q == '0) begin
                     state_q <= StIdle;
                     done    <= 1'b1;
                  end else begin
                     addr_q  <= addr_q + ADDR_W'(1);
                     rem_q   <= rem_q - ADDR_W'(1);
                     state_q <= StRd;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dff_mem_master.sv
// Self-checking bench for dff_mem_master: a behavioural RAM on the pins, a
// word-array reference of expected contents, vector table plus random bursts.
module tb_dff_mem_master;
   import dff_mem_pkg::*;

   localparam int unsigned AW = ADDR_W_DEF;
   localparam int unsigned DW = DATA_W_DEF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr, cmd_len;
   logic          wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid, rd_ready;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   wire  [DW-1:0] mem_rdata;
   logic          mem_lr_n, mem_ce_n, busy, done;

   always #5 clk = ~clk;

   dff_mem_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_lr_n  (mem_lr_n),
      .mem_ce_n  (mem_ce_n),
      .busy      (busy),
      .done      (done)
   );

   // Behavioural RAM attached to the pins, plus a log of every committed write.
   logic [DW-1:0] ram [RAM_BYTES];
   logic [DW-1:0] ref_mem [RAM_BYTES];
   logic          clear_ram = 1'b1;
   logic [AW-1:0] wlog_a [$];
   logic [DW-1:0] wlog_d [$];
   int            ce_cnt = 0;
   int            checks = 0;
   int            errors = 0;
   logic          done_prev = 1'b0;

   assign mem_rdata = !mem_ce_n ? ram[mem_addr] : 'z;

   always @(posedge clk) begin
      if (clear_ram) begin
         for (int i = 0; i < int'(RAM_BYTES); i++) ram[i] <= '0;
      end else if (!mem_lr_n) begin
         ram[mem_addr] <= mem_wdata;
         wlog_a.push_back(mem_addr);
         wlog_d.push_back(mem_wdata);
      end
      if (!mem_ce_n) ce_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("inv_lr_ce_overlap", 32'(!mem_lr_n && !mem_ce_n), 0);
         chk("inv_ready_while_busy", 32'(cmd_ready && busy), 0);
         chk("inv_done_width", 32'(done && done_prev), 0);
      end
      done_prev <= done;
   end

   task automatic chk_ram(input string tag);
      int bad = 0;
      for (int i = 0; i < int'(RAM_BYTES); i++) if (ram[i] !== ref_mem[i]) bad++;
      chk({tag, "_ram_contents"}, bad, 0);
   endtask

   // Called just after a negedge; returns just after a negedge.
   task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l,
                           input logic [RAM_BYTES-1:0][DW-1:0] d, input int gap,
                           input string tag);
      int n0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
      #1 chk({tag, "_cmd_ready"}, cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      n0 = wlog_a.size();
      for (int i = 0; i <= int'(l); i++) begin
         for (int g = 0; g < gap; g++) begin
            #1 chk({tag, "_gap_lr_n"}, mem_lr_n, 1);
            @(negedge clk);
         end
         wr_valid = 1'b1; wr_data = d[i];
         #1;
         chk({tag, "_wr_ready"}, wr_ready, 1);
         chk({tag, "_lr_n"}, mem_lr_n, 0);
         chk({tag, "_mem_addr"}, mem_addr, (int'(a) + i) % int'(RAM_BYTES));
         chk({tag, "_mem_wdata"}, mem_wdata, d[i]);
         @(negedge clk);
         wr_valid = 1'b0;
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_write_count"}, wlog_a.size() - n0, int'(l) + 1);
      for (int i = 0; i <= int'(l) && n0 + i < wlog_a.size(); i++) begin
         chk($sformatf("%s_log_addr%0d", tag, i), wlog_a[n0+i], (int'(a) + i) % int'(RAM_BYTES));
         chk($sformatf("%s_log_data%0d", tag, i), wlog_d[n0+i], d[i]);
      end
      for (int i = 0; i <= int'(l); i++) ref_mem[(int'(a) + i) % int'(RAM_BYTES)] = d[i];
      chk_ram(tag);
      @(negedge clk);
      chk({tag, "_done_drop"}, done, 0);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input int stall,
                          input string tag, output logic [RAM_BYTES-1:0][DW-1:0] got);
      int ce0;
      int t;
      got = '0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
      #1 chk({tag, "_cmd_ready"}, cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      ce0 = ce_cnt;
      for (int i = 0; i <= int'(l); i++) begin
         t = 0;
         while (!rd_valid && t < 8) begin
            @(negedge clk);
            t++;
         end
         chk($sformatf("%s_rd_latency%0d", tag, i), t, 1);
         if (!rd_valid) return;
         got[i] = rd_data;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {rd_valid, rd_data}, {1'b1, got[i]});
         end
         rd_ready = 1'b1;
         @(negedge clk);
         rd_ready = 1'b0;
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_ce_cycles"}, ce_cnt - ce0, int'(l) + 1);
      @(negedge clk);
      chk({tag, "_done_drop"}, done, 0);
   endtask

   typedef struct {
      bit                          is_wr;
      logic [AW-1:0]               addr;
      logic [AW-1:0]               len;
      logic [RAM_BYTES-1:0][DW-1:0] data;  // write bytes, or expected read bytes
      int                          gap;
      int                          stall;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [RAM_BYTES-1:0][DW-1:0] got;
      logic [RAM_BYTES-1:0][DW-1:0] d;
      logic [AW-1:0]                ra, rl;
      int                           n0;

      for (int i = 0; i < 8; i++) begin
         vecs[i].data = '0; vecs[i].gap = 0; vecs[i].stall = 0;
      end
      vecs[0].is_wr = 1; vecs[0].addr = 5;  vecs[0].len = 0;  vecs[0].data[0] = 8'hA5;
      vecs[1].is_wr = 0; vecs[1].addr = 5;  vecs[1].len = 0;  vecs[1].data[0] = 8'hA5;
      vecs[2].is_wr = 1; vecs[2].addr = 0;  vecs[2].len = 15;
      vecs[3].is_wr = 0; vecs[3].addr = 0;  vecs[3].len = 15;
      for (int i = 0; i < 16; i++) begin
         vecs[2].data[i] = 8'(i * 8'h11);
         vecs[3].data[i] = 8'(i * 8'h11);
      end
      vecs[4].is_wr = 0; vecs[4].addr = 0;  vecs[4].len = 2;  vecs[4].stall = 3;
      vecs[4].data[0] = 8'h00; vecs[4].data[1] = 8'h11; vecs[4].data[2] = 8'h22;
      vecs[5].is_wr = 1; vecs[5].addr = 14; vecs[5].len = 3;  vecs[5].gap = 1;
      vecs[6].is_wr = 0; vecs[6].addr = 14; vecs[6].len = 3;
      for (int i = 0; i < 4; i++) begin
         vecs[5].data[i] = 8'(i + 1);
         vecs[6].data[i] = 8'(i + 1);
      end
      vecs[7].is_wr = 0; vecs[7].addr = 5;  vecs[7].len = 0;  vecs[7].data[0] = 8'h55;

      for (int i = 0; i < int'(RAM_BYTES); i++) ref_mem[i] = '0;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_outputs", {rd_valid, rd_data, done, busy, mem_lr_n, mem_ce_n, mem_addr, mem_wdata},
          {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00});
      clear_ram = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         if (vecs[v].is_wr) begin
            do_write(vecs[v].addr, vecs[v].len, vecs[v].data, vecs[v].gap, $sformatf("vec%0d", v));
         end else begin
            do_read(vecs[v].addr, vecs[v].len, vecs[v].stall, $sformatf("vec%0d", v), got);
            for (int i = 0; i <= int'(vecs[v].len); i++)
               chk($sformatf("vec%0d_rd_data%0d", v, i), got[i], vecs[v].data[i]);
         end
      end

      // Reset after the second beat of a 4-byte write to address 8.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd8; cmd_len = 4'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      n0 = wlog_a.size();
      for (int i = 0; i < 2; i++) begin
         wr_valid = 1'b1; wr_data = 8'hC0 + 8'(i);
         @(negedge clk);
      end
      wr_data = 8'hC2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_lr_n", mem_lr_n, 1);
      chk("mid_rst_ready", {cmd_ready, wr_ready}, 2'b00);
      @(negedge clk);
      chk("mid_rst_outputs", {rd_valid, done, busy, mem_lr_n, mem_ce_n, mem_addr, mem_wdata},
          {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00});
      rst_n = 1'b1; wr_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_cmd_ready_after", cmd_ready, 1);
      chk("mid_rst_no_done", done, 0);
      chk("mid_rst_write_count", wlog_a.size() - n0, 2);
      ref_mem[8] = 8'hC0;
      ref_mem[9] = 8'hC1;
      chk_ram("mid_rst");

      // Random bursts against the reference array.
      for (int r = 0; r < 12; r++) begin
         ra = AW'($urandom_range(0, RAM_BYTES - 1));
         rl = AW'($urandom_range(0, RAM_BYTES - 1));
         for (int i = 0; i < int'(RAM_BYTES); i++) d[i] = DW'($urandom);
         do_write(ra, rl, d, $urandom_range(0, 2), $sformatf("rnd%0d_wr", r));
         ra = AW'($urandom_range(0, RAM_BYTES - 1));
         rl = AW'($urandom_range(0, RAM_BYTES - 1));
         do_read(ra, rl, $urandom_range(0, 2), $sformatf("rnd%0d_rd", r), got);
         for (int i = 0; i <= int'(rl); i++)
            chk($sformatf("rnd%0d_rd_data%0d", r, i), got[i],
                ref_mem[(int'(ra) + i) % int'(RAM_BYTES)]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1);
   end

endmodule
